// File: rtl/d5m_pkg.sv
// -----------------------------------------------------------------------------
// d5m_pkg
// Shared definitions for the D5M camera capture front end:
//   - state_e : capture FSM state encoding
//   - FIFO word layout {error, eop, sop, data}: the pixel occupies bits
//     [DATA_W-1:0] and the three framing flags sit directly above it. The
//     index helpers return the flag bit positions for a given pixel width.
// -----------------------------------------------------------------------------
package d5m_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,   // waiting for an armed frame start
        WAIT_LV = 3'd1,   // frame open, waiting for the first line
        ACTIVE  = 3'd2,   // pixels are being forwarded
        DROP    = 3'd3,   // frame finished or faulted, discard until FV falls
        FINISH  = 3'd4    // emit the error terminator if one is owed
    } state_e;

    // Number of framing flag bits stored next to each pixel.
    localparam int unsigned CTRL_W = 3;

    function automatic int unsigned sop_idx(input int unsigned data_w);
        return data_w;
    endfunction

    function automatic int unsigned eop_idx(input int unsigned data_w);
        return data_w + 1;
    endfunction

    function automatic int unsigned err_idx(input int unsigned data_w);
        return data_w + 2;
    endfunction

endpackage

// File: rtl/d5m_fifo_fwft.sv
// -----------------------------------------------------------------------------
// d5m_fifo_fwft
// First-word-fall-through FIFO: the head entry is visible on rd_data whenever
// empty is low, and rd_en consumes it. A write while full is accepted only if
// a read happens in the same cycle.
// Ports:
//   clk, rst        clock, synchronous active-high reset (pointers only)
//   wr_en, wr_data  write request and word
//   rd_en           consume head word (ignored while empty)
//   rd_data         head word (undefined while empty)
//   full, empty     occupancy flags
// -----------------------------------------------------------------------------
module d5m_fifo_fwft #(
    parameter int unsigned W     = 11,
    parameter int unsigned DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_wr, do_rd;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage has no reset; emptiness is defined by the pointers alone,
    // so clearing the array would only cost a reset net on every bit.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/d5m_stream_capture.sv
// -----------------------------------------------------------------------------
// d5m_stream_capture
// Camera capture front end: samples the sensor FV/LV/pixel bus, checks frame
// geometry and emits framed Avalon-ST beats through an output FIFO.
// Optional feature macro: D5M_TEST_PATTERN_EN -- when defined and test_mode=1
// the pixel is replaced by (col + line) truncated to DATA_W.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start, continuous           single-shot arm pulse / capture every frame
//   test_mode                   test pattern select (macro dependent)
//   frame_valid, line_valid     sensor FV / LV
//   data_in                     sensor pixel
//   out_valid, out_ready        stream handshake
//   out_data, out_sop, out_eop  pixel and frame delimiters
//   out_error                   with eop: frame faulty, discard
//   busy                        FSM not idle
//   overflow                    sticky FIFO overflow, cleared by rst or start
//   frame_count                 completed error-free frames (wrapping)
// -----------------------------------------------------------------------------
module d5m_stream_capture
    import d5m_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned COLS       = 800,
    parameter int unsigned LINES      = 480,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
    input  logic              test_mode,
    input  logic              frame_valid,
    input  logic              line_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic              out_error,
    output logic              busy,
    output logic              overflow,
    output logic [15:0]       frame_count
);

    localparam int unsigned CW     = $clog2(COLS + 1);
    localparam int unsigned LW     = $clog2(LINES + 1);
    localparam int unsigned WORD_W = DATA_W + CTRL_W;
    localparam int unsigned SOP_B  = sop_idx(DATA_W);
    localparam int unsigned EOP_B  = eop_idx(DATA_W);
    localparam int unsigned ERR_B  = err_idx(DATA_W);

    localparam logic [CW-1:0] COL_END   = CW'(COLS);
    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
    localparam logic [LW-1:0] LINE_END  = LW'(LINES);
    localparam logic [LW-1:0] LINE_LAST = LW'(LINES - 1);

    // Sensor sampling: s1 is the working stage, s2 only serves edge detection.
    logic              fv1_q, lv1_q, fv2_q, lv2_q;
    logic [DATA_W-1:0] data1_q;

    // Control state
    state_e            state_q, state_d;
    logic              armed_q, armed_d;
    logic              fault_q, fault_d;
    logic [CW-1:0]     col_q, col_d;
    logic [LW-1:0]     line_q, line_d;
    logic              push_q, push_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       frame_count_q, frame_count_d;

    logic              fv_rise, fv_fall, lv_rise, lv_fall;
    logic [DATA_W-1:0] pix;
    logic              fifo_full, fifo_empty, fifo_wr, pop, ovf_evt;
    logic [WORD_W-1:0] fifo_rd;

    // NOTE: the sampling stage is not reset. It keeps following the sensor
    // during rst, so a frame already in progress when rst drops shows no FV
    // edge and capture resyncs on the next genuine FV rise.
    always_ff @(posedge clk) begin
        fv1_q   <= frame_valid;
        lv1_q   <= line_valid;
        data1_q <= data_in;
        fv2_q   <= fv1_q;
        lv2_q   <= lv1_q;
    end

    assign fv_rise = fv1_q && !fv2_q;
    assign fv_fall = !fv1_q && fv2_q;
    assign lv_rise = lv1_q && !lv2_q;
    assign lv_fall = !lv1_q && lv2_q;

`ifdef D5M_TEST_PATTERN_EN
    assign pix = test_mode ? DATA_W'(32'(col_q) + 32'(line_q)) : data1_q;
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode;
    assign pix = data1_q;
`endif

    // Pushes are staged one cycle in push_q/word_q; the full check happens at
    // the FIFO write, so an overflow is reported back to the FSM here.
    assign pop     = !fifo_empty && out_ready;
    assign fifo_wr = push_q && (!fifo_full || pop);
    assign ovf_evt = push_q && fifo_full && !pop;

    // NOTE: every variable gets its default at the top of the block, so no
    // path through the case statement can leave one unassigned (no latches).
    always_comb begin
        state_d       = state_q;
        armed_d       = armed_q;
        fault_d       = fault_q;
        col_d         = col_q;
        line_d        = line_q;
        push_d        = 1'b0;
        word_d        = '0;
        overflow_d    = (overflow_q && !start) || ovf_evt;
        frame_count_d = frame_count_q;

        // A frame counts as complete only once its clean eop lands in the FIFO.
        if (fifo_wr && word_q[EOP_B] && !word_q[ERR_B])
            frame_count_d = frame_count_q + 16'd1;

        unique case (state_q)
            IDLE: begin
                armed_d = armed_q || start;
                if ((continuous || armed_q || start) && fv_rise) begin
                    state_d = WAIT_LV;
                    armed_d = 1'b0;
                    fault_d = 1'b0;
                    col_d   = '0;
                    line_d  = '0;
                end
            end

            WAIT_LV, ACTIVE: begin
                if (ovf_evt) begin
                    fault_d = 1'b1;
                    state_d = fv_fall ? FINISH : DROP;
                end else if (fv_fall) begin
                    // The clean last pixel moves to DROP, so FV falling here
                    // always means the frame ended early.
                    fault_d = 1'b1;
                    state_d = FINISH;
                end else if (state_q == WAIT_LV && !lv_rise) begin
                    state_d = WAIT_LV;
                end else if (lv1_q) begin
                    if (col_q == COL_END || line_q == LINE_END) begin
                        fault_d = 1'b1;
                        state_d = DROP;
                    end else begin
                        push_d                = 1'b1;
                        word_d[DATA_W-1:0]    = pix;
                        word_d[SOP_B]         = (col_q == '0) && (line_q == '0);
                        word_d[EOP_B]         = (col_q == COL_LAST) && (line_q == LINE_LAST);
                        col_d                 = col_q + 1'b1;
                        // After the last pixel the rest of the frame is ignored.
                        state_d               = word_d[EOP_B] ? DROP : ACTIVE;
                    end
                end else if (lv_fall) begin
                    if (col_q != COL_END) begin
                        fault_d = 1'b1;
                        state_d = DROP;
                    end else begin
                        col_d  = '0;
                        line_d = line_q + 1'b1;
                    end
                end
            end

            DROP: begin
                if (ovf_evt) fault_d = 1'b1;
                if (fv_fall) state_d = FINISH;
            end

            FINISH: begin
                // Wait for any staged word to resolve so fault_q is final; the
                // terminator is only staged when the FIFO cannot be full at its
                // write (no other push can intervene).
                if (ovf_evt) begin
                    fault_d = 1'b1;
                end else if (!push_q) begin
                    if (!fault_q) begin
                        state_d = IDLE;
                    end else if (!fifo_full) begin
                        push_d        = 1'b1;
                        word_d[EOP_B] = 1'b1;
                        word_d[ERR_B] = 1'b1;
                        fault_d       = 1'b0;
                        state_d       = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values computed before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            armed_q       <= 1'b0;
            fault_q       <= 1'b0;
            col_q         <= '0;
            line_q        <= '0;
            push_q        <= 1'b0;
            word_q        <= '0;
            overflow_q    <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            armed_q       <= armed_d;
            fault_q       <= fault_d;
            col_q         <= col_d;
            line_q        <= line_d;
            push_q        <= push_d;
            word_q        <= word_d;
            overflow_q    <= overflow_d;
            frame_count_q <= frame_count_d;
        end
    end

    d5m_fifo_fwft #(
        .W     (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data (word_q),
        .rd_en   (out_ready),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Gate the head word with valid so idle outputs read as zero.
    assign out_valid   = !fifo_empty;
    assign out_data    = out_valid ? fifo_rd[DATA_W-1:0] : '0;
    assign out_sop     = out_valid && fifo_rd[SOP_B];
    assign out_eop     = out_valid && fifo_rd[EOP_B];
    assign out_error   = out_valid && fifo_rd[ERR_B];
    assign busy        = (state_q != IDLE);
    assign overflow    = overflow_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_d5m_stream_capture.sv
// -----------------------------------------------------------------------------
// tb_d5m_stream_capture
// Scoreboard bench for d5m_stream_capture (COLS=4, LINES=2, FIFO_DEPTH=4).
// Each frame is described as a list of line lengths plus pixel values; a
// raster-walk model turns that description into the expected beat list,
// which a negedge monitor consumes as the DUT hands out beats.
// -----------------------------------------------------------------------------
module tb_d5m_stream_capture;

    localparam int DATA_W     = 8;
    localparam int COLS       = 4;
    localparam int LINES      = 2;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              continuous = 1'b0;
    logic              test_mode = 1'b0;
    logic              frame_valid = 1'b0;
    logic              line_valid = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              out_ready = 1'b1;
    logic              out_valid, out_sop, out_eop, out_error, busy, overflow;
    logic [DATA_W-1:0] out_data;
    logic [15:0]       frame_count;

    d5m_stream_capture #(
        .DATA_W     (DATA_W),
        .COLS       (COLS),
        .LINES      (LINES),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .continuous  (continuous),
        .test_mode   (test_mode),
        .frame_valid (frame_valid),
        .line_valid  (line_valid),
        .data_in     (data_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .out_error   (out_error),
        .busy        (busy),
        .overflow    (overflow),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [10:0] exp_q[$];          // {error, eop, sop, data}
    logic [15:0] exp_frames = '0;

    // Current frame description
    int          n_lines;
    int          len_tab [4];
    logic [7:0]  px_mem  [4][8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted beat is compared with the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got {err,eop,sop,data}=0x%0h, required no beat",
                         {out_error, out_eop, out_sop, out_data});
            end else begin
                logic [10:0] e;
                e = exp_q.pop_front();
                check("beat", {out_error, out_eop, out_sop, out_data}, e);
            end
        end
    end

    // Reference: walk the frame in raster order applying the capture rules.
    // bp models out_ready held low for the whole frame (FIFO only fills).
    task automatic model_frame(input bit armed, input bit bp, input bit tmode);
        bit   done  = 1'b0;
        bit   fault = 1'b0;
        int   acc   = 0;
        bit   pat   = 1'b0;
        logic [7:0] d;
`ifdef D5M_TEST_PATTERN_EN
        pat = tmode;
`else
        pat = 1'b0 & tmode;
`endif
        if (!armed) return;
        for (int l = 0; l < n_lines; l++) begin
            if (done || fault) break;
            for (int c = 0; c < len_tab[l]; c++) begin
                if (c >= COLS || l >= LINES) begin fault = 1'b1; break; end
                if (bp && acc == FIFO_DEPTH) begin fault = 1'b1; break; end
                d = pat ? 8'(c + l) : px_mem[l][c];
                exp_q.push_back({1'b0, (c == COLS-1 && l == LINES-1), (c == 0 && l == 0), d});
                acc++;
                if (c == COLS-1 && l == LINES-1) begin done = 1'b1; break; end
            end
            if (!done && !fault && len_tab[l] != COLS) fault = 1'b1;
        end
        if (!done && !fault) fault = 1'b1;
        if (fault) exp_q.push_back({1'b1, 1'b1, 1'b0, 8'h00});
        else       exp_frames = exp_frames + 16'd1;
    endtask

    task automatic set_clean(input logic [7:0] base);
        n_lines = LINES;
        for (int l = 0; l < 4; l++) begin
            len_tab[l] = COLS;
            for (int c = 0; c < 8; c++) px_mem[l][c] = base + 8'(l * COLS + c);
        end
    endtask

    task automatic drive_lines(input bit exp_busy, input string tag);
        for (int l = 0; l < n_lines; l++) begin
            if (l == 0) check({tag, "_busy"}, busy, exp_busy);
            for (int c = 0; c < len_tab[l]; c++) begin
                line_valid = 1'b1;
                data_in    = px_mem[l][c];
                tick();
            end
            line_valid = 1'b0;
            data_in    = 8'($urandom);
            repeat (3) tick();
        end
    endtask

    task automatic send_frame(input bit bp, input bit exp_busy, input string tag);
        out_ready   = !bp;
        frame_valid = 1'b1;
        repeat (2) tick();
        drive_lines(exp_busy, tag);
        frame_valid = 1'b0;
        repeat (4) tick();
        out_ready = 1'b1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || busy || out_valid) && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_drained"}, exp_q.size(), 0);
        check({tag, "_idle"}, busy, 1'b0);
        check({tag, "_fcnt"}, frame_count, exp_frames);
    endtask

    task automatic run_frame(input bit armed, input bit bp, input string tag);
        model_frame(armed, bp, test_mode);
        send_frame(bp, armed, tag);
        drain(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, out_valid, 1'b0);
        check({tag, "_data"},  out_data, 8'h00);
        check({tag, "_flags"}, {out_sop, out_eop, out_error}, 3'b000);
        check({tag, "_busy"},  busy, 1'b0);
        check({tag, "_ovf"},   overflow, 1'b0);
        check({tag, "_fcnt"},  frame_count, 16'h0000);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        continuous = 1'b1;
        tick();

        // Clean frame 0x10..0x17
        set_clean(8'h10);
        run_frame(1'b1, 1'b0, "clean");

        // Long line on line 0: four pixels, then error terminator
        set_clean(8'h20);
        len_tab[0] = COLS + 1;
        run_frame(1'b1, 1'b0, "long_line");

        // Extra pixel on the last line comes after eop: silently dropped
        set_clean(8'h30);
        len_tab[1] = COLS + 1;
        run_frame(1'b1, 1'b0, "long_last");

        // Short line
        set_clean(8'h40);
        len_tab[0] = COLS - 1;
        run_frame(1'b1, 1'b0, "short_line");

        // Short frame: FV falls after one line
        set_clean(8'h50);
        n_lines = 1;
        run_frame(1'b1, 1'b0, "short_frame");

        // Lines beyond the last one are ignored after a clean eop
        set_clean(8'h60);
        n_lines = LINES + 1;
        run_frame(1'b1, 1'b0, "extra_lines");

        // Single-shot: unarmed frame is ignored, start arms exactly one frame
        continuous = 1'b0;
        set_clean(8'h70);
        run_frame(1'b0, 1'b0, "unarmed");
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        set_clean(8'h80);
        run_frame(1'b1, 1'b0, "armed");
        set_clean(8'h90);
        run_frame(1'b0, 1'b0, "rearm_needed");

        // Backpressure across the whole frame: overflow and terminator
        continuous = 1'b1;
        set_clean(8'hA0);
        run_frame(1'b1, 1'b1, "backpressure");
        check("ovf_sticky", overflow, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ovf_cleared", overflow, 1'b0);

        // Test pattern frame (pattern only when the feature is built in)
        test_mode = 1'b1;
        set_clean(8'hB0);
        run_frame(1'b1, 1'b0, "pattern");
        test_mode = 1'b0;

        // FV rises during rst, rst drops mid-frame: nothing until next FV rise
        set_clean(8'hC0);
        rst = 1'b1;
        tick();
        frame_valid = 1'b1;
        repeat (2) tick();
        check_reset_outputs("rst_mid");
        rst = 1'b0;
        exp_frames = '0;
        tick();
        drive_lines(1'b0, "resync_skip");
        frame_valid = 1'b0;
        repeat (4) tick();
        drain("resync_skip");
        set_clean(8'hD0);
        run_frame(1'b1, 1'b0, "resync");

        // Randomised geometry, data and test_mode
        for (int i = 0; i < 16; i++) begin
            n_lines = int'($urandom_range(1, 3));
            for (int l = 0; l < 4; l++) begin
                case ($urandom_range(0, 4))
                    0:       len_tab[l] = COLS - 1;
                    1:       len_tab[l] = COLS + 1;
                    default: len_tab[l] = COLS;
                endcase
                for (int c = 0; c < 8; c++) px_mem[l][c] = 8'($urandom);
            end
            test_mode = 1'($urandom);
            run_frame(1'b1, 1'b0, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
